// File: rtl/ps2_kb_pkg.sv
// Shared constants for the PS/2 keyboard front end: protocol byte values,
// receiver state encoding and the Z88 keyboard matrix bit positions
// (index = row*8 + col).
package ps2_kb_pkg;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_F12  = 8'h07;
    localparam logic [7:0] PS2_OVF0 = 8'h00;
    localparam logic [7:0] PS2_OVF1 = 8'hFF;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Row 0
    localparam logic [5:0] KEY_8        = 6'd0;
    localparam logic [5:0] KEY_7        = 6'd1;
    localparam logic [5:0] KEY_N        = 6'd2;
    localparam logic [5:0] KEY_H        = 6'd3;
    localparam logic [5:0] KEY_Y        = 6'd4;
    localparam logic [5:0] KEY_6        = 6'd5;
    localparam logic [5:0] KEY_ENTER    = 6'd6;
    localparam logic [5:0] KEY_DEL      = 6'd7;
    // Row 1
    localparam logic [5:0] KEY_I        = 6'd8;
    localparam logic [5:0] KEY_U        = 6'd9;
    localparam logic [5:0] KEY_B        = 6'd10;
    localparam logic [5:0] KEY_G        = 6'd11;
    localparam logic [5:0] KEY_T        = 6'd12;
    localparam logic [5:0] KEY_5        = 6'd13;
    localparam logic [5:0] KEY_UP       = 6'd14;
    localparam logic [5:0] KEY_BSLASH   = 6'd15;
    // Row 2
    localparam logic [5:0] KEY_O        = 6'd16;
    localparam logic [5:0] KEY_J        = 6'd17;
    localparam logic [5:0] KEY_V        = 6'd18;
    localparam logic [5:0] KEY_F        = 6'd19;
    localparam logic [5:0] KEY_R        = 6'd20;
    localparam logic [5:0] KEY_4        = 6'd21;
    localparam logic [5:0] KEY_DOWN     = 6'd22;
    localparam logic [5:0] KEY_EQUAL    = 6'd23;
    // Row 3
    localparam logic [5:0] KEY_9        = 6'd24;
    localparam logic [5:0] KEY_K        = 6'd25;
    localparam logic [5:0] KEY_C        = 6'd26;
    localparam logic [5:0] KEY_D        = 6'd27;
    localparam logic [5:0] KEY_E        = 6'd28;
    localparam logic [5:0] KEY_3        = 6'd29;
    localparam logic [5:0] KEY_RIGHT    = 6'd30;
    localparam logic [5:0] KEY_MINUS    = 6'd31;
    // Row 4
    localparam logic [5:0] KEY_P        = 6'd32;
    localparam logic [5:0] KEY_M        = 6'd33;
    localparam logic [5:0] KEY_X        = 6'd34;
    localparam logic [5:0] KEY_S        = 6'd35;
    localparam logic [5:0] KEY_W        = 6'd36;
    localparam logic [5:0] KEY_2        = 6'd37;
    localparam logic [5:0] KEY_LEFT     = 6'd38;
    localparam logic [5:0] KEY_RBRACKET = 6'd39;
    // Row 5
    localparam logic [5:0] KEY_0        = 6'd40;
    localparam logic [5:0] KEY_L        = 6'd41;
    localparam logic [5:0] KEY_Z        = 6'd42;
    localparam logic [5:0] KEY_A        = 6'd43;
    localparam logic [5:0] KEY_Q        = 6'd44;
    localparam logic [5:0] KEY_1        = 6'd45;
    localparam logic [5:0] KEY_SPACE    = 6'd46;
    localparam logic [5:0] KEY_LBRACKET = 6'd47;
    // Row 6
    localparam logic [5:0] KEY_QUOTE    = 6'd48;
    localparam logic [5:0] KEY_SEMI     = 6'd49;
    localparam logic [5:0] KEY_COMMA    = 6'd50;
    localparam logic [5:0] KEY_MENU     = 6'd51;
    localparam logic [5:0] KEY_DIAMOND  = 6'd52;
    localparam logic [5:0] KEY_TAB      = 6'd53;
    localparam logic [5:0] KEY_LSHIFT   = 6'd54;
    localparam logic [5:0] KEY_HELP     = 6'd55;
    // Row 7
    localparam logic [5:0] KEY_POUND    = 6'd56;
    localparam logic [5:0] KEY_SLASH    = 6'd57;
    localparam logic [5:0] KEY_PERIOD   = 6'd58;
    localparam logic [5:0] KEY_CAPS     = 6'd59;
    localparam logic [5:0] KEY_INDEX    = 6'd60;
    localparam logic [5:0] KEY_ESC      = 6'd61;
    localparam logic [5:0] KEY_SQUARE   = 6'd62;
    localparam logic [5:0] KEY_RSHIFT   = 6'd63;

    // True when the eight data bits plus the parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_keymap.sv
// Scan code set 2 to Z88 matrix index ROM. Input is {ext, code}; codes
// without a Z88 equivalent (including F12, which drives the flap) are invalid.
module ps2_keymap
    import ps2_kb_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    output logic       valid,
    output logic [5:0] idx
);

    // Pure lookup; every unlisted {ext, code} reports invalid.
    always_comb begin
        valid = 1'b1;
        idx   = 6'd0;
        case ({ext, code})
            9'h03E: idx = KEY_8;
            9'h03D: idx = KEY_7;
            9'h031: idx = KEY_N;
            9'h033: idx = KEY_H;
            9'h035: idx = KEY_Y;
            9'h036: idx = KEY_6;
            9'h05A: idx = KEY_ENTER;
            9'h066: idx = KEY_DEL;
            9'h171: idx = KEY_DEL;
            9'h043: idx = KEY_I;
            9'h03C: idx = KEY_U;
            9'h032: idx = KEY_B;
            9'h034: idx = KEY_G;
            9'h02C: idx = KEY_T;
            9'h02E: idx = KEY_5;
            9'h175: idx = KEY_UP;
            9'h05D: idx = KEY_BSLASH;
            9'h044: idx = KEY_O;
            9'h03B: idx = KEY_J;
            9'h02A: idx = KEY_V;
            9'h02B: idx = KEY_F;
            9'h02D: idx = KEY_R;
            9'h025: idx = KEY_4;
            9'h172: idx = KEY_DOWN;
            9'h055: idx = KEY_EQUAL;
            9'h046: idx = KEY_9;
            9'h042: idx = KEY_K;
            9'h021: idx = KEY_C;
            9'h023: idx = KEY_D;
            9'h024: idx = KEY_E;
            9'h026: idx = KEY_3;
            9'h174: idx = KEY_RIGHT;
            9'h04E: idx = KEY_MINUS;
            9'h04D: idx = KEY_P;
            9'h03A: idx = KEY_M;
            9'h022: idx = KEY_X;
            9'h01B: idx = KEY_S;
            9'h01D: idx = KEY_W;
            9'h01E: idx = KEY_2;
            9'h16B: idx = KEY_LEFT;
            9'h05B: idx = KEY_RBRACKET;
            9'h045: idx = KEY_0;
            9'h04B: idx = KEY_L;
            9'h01A: idx = KEY_Z;
            9'h01C: idx = KEY_A;
            9'h015: idx = KEY_Q;
            9'h016: idx = KEY_1;
            9'h029: idx = KEY_SPACE;
            9'h054: idx = KEY_LBRACKET;
            9'h052: idx = KEY_QUOTE;
            9'h04C: idx = KEY_SEMI;
            9'h041: idx = KEY_COMMA;
            9'h004: idx = KEY_MENU;
            9'h014: idx = KEY_DIAMOND;
            9'h114: idx = KEY_DIAMOND;
            9'h00D: idx = KEY_TAB;
            9'h012: idx = KEY_LSHIFT;
            9'h005: idx = KEY_HELP;
            9'h00E: idx = KEY_POUND;
            9'h04A: idx = KEY_SLASH;
            9'h049: idx = KEY_PERIOD;
            9'h058: idx = KEY_CAPS;
            9'h006: idx = KEY_INDEX;
            9'h076: idx = KEY_ESC;
            9'h011: idx = KEY_SQUARE;
            9'h111: idx = KEY_SQUARE;
            9'h059: idx = KEY_RSHIFT;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_kbmatrix.sv
// PS/2 keyboard receiver and decoder producing the Z88 key matrix and the
// flap switch. Raw lines are synchronised and debounced, 11-bit frames are
// validated, and E0/F0 prefixes steer one matrix bit per make/break code.
module ps2_kbmatrix
    import ps2_kb_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [63:0] kbmatrix,
    output logic        flap,
    output logic [7:0]  rx_code,
    output logic        rx_stb,
    output logic        rx_err
);

    localparam int             FCW       = $clog2(FILTER_LEN + 1);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [14:0]    TO_LAST   = 15'(TIMEOUT_CYC - 1);

    logic [1:0]     clk_sync;
    logic [1:0]     data_sync;
    logic           clk_filt;
    logic           data_filt;
    logic [FCW-1:0] clk_cnt;
    logic [FCW-1:0] data_cnt;
    logic           fall;

    rx_state_t      state;
    rx_state_t      state_next;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift_reg;
    logic           par_bit;
    logic [14:0]    idle_cnt;
    logic           timeout_hit;
    logic           shift_en;
    logic           par_en;
    logic           cnt_clr;
    logic           frame_ok;
    logic           frame_bad;

    logic           ext;
    logic           brk;
    logic           map_valid;
    logic [5:0]     map_idx;

    // Input conditioning: two-flop synchronizers, idle-high after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Clock-line filter; the filtered falling edge is registered as the fall strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_filt <= 1'b1;
            clk_cnt  <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                clk_cnt <= '0;
            end else if (clk_cnt == FILT_LAST) begin
                clk_filt <= clk_sync[1];
                clk_cnt  <= '0;
                fall     <= clk_filt;
            end else begin
                clk_cnt <= clk_cnt + FCW'(1);
            end
        end
    end

    // Data-line filter, same rule as the clock line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_filt <= 1'b1;
            data_cnt  <= '0;
        end else if (data_sync[1] == data_filt) begin
            data_cnt <= '0;
        end else if (data_cnt == FILT_LAST) begin
            data_filt <= data_sync[1];
            data_cnt  <= '0;
        end else begin
            data_cnt <= data_cnt + FCW'(1);
        end
    end

    // Cycles since the last fall; saturates so a stuck line cannot wrap it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if (fall) begin
            idle_cnt <= '0;
        end else if (idle_cnt != '1) begin
            idle_cnt <= idle_cnt + 15'd1;
        end
    end

    assign timeout_hit = !fall && (idle_cnt >= TO_LAST);

    // Receiver state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Receiver next-state and per-cycle frame controls.
    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        par_en     = 1'b0;
        cnt_clr    = 1'b0;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        if (state != RX_IDLE && timeout_hit) begin
            state_next = RX_IDLE;
            frame_bad  = 1'b1;
        end else if (fall) begin
            case (state)
                RX_IDLE: begin
                    if (!data_filt) begin
                        state_next = RX_DATA;
                        cnt_clr    = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end
                RX_DATA: begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_next = RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    par_en     = 1'b1;
                    state_next = RX_STOP;
                end
                RX_STOP: begin
                    if (data_filt && odd_parity_ok(shift_reg, par_bit)) begin
                        frame_ok = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                    state_next = RX_IDLE;
                end
                default: state_next = RX_IDLE;
            endcase
        end
    end

    // Data bit counter within the frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= '0;
        end else if (cnt_clr) begin
            bit_cnt <= '0;
        end else if (shift_en) begin
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // Frame payload capture, LSB first; no reset needed since it is only read once qualified.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            shift_reg <= {data_filt, shift_reg[7:1]};
        end
        if (par_en) begin
            par_bit <= data_filt;
        end
    end

    // Registered receiver outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_code <= 8'h00;
            rx_stb  <= 1'b0;
            rx_err  <= 1'b0;
        end else begin
            rx_stb <= frame_ok;
            rx_err <= frame_bad;
            if (frame_ok) begin
                rx_code <= shift_reg;
            end
        end
    end

    ps2_keymap u_keymap (
        .ext   (ext),
        .code  (rx_code),
        .valid (map_valid),
        .idx   (map_idx)
    );

    // Decoder: prefixes, overflow, matrix bit update and flap toggle, one cycle after rx_stb.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kbmatrix <= '1;
            flap     <= 1'b0;
            ext      <= 1'b0;
            brk      <= 1'b0;
        end else if (rx_err) begin
            // A broken frame must not leave a prefix armed for the next key.
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (rx_stb) begin
            case (rx_code)
                PS2_EXT: ext <= 1'b1;
                PS2_BRK: brk <= 1'b1;
                PS2_OVF0, PS2_OVF1: begin
                    kbmatrix <= '1;
                    ext      <= 1'b0;
                    brk      <= 1'b0;
                end
                default: begin
                    if (map_valid) begin
                        kbmatrix[map_idx] <= brk;
                    end
                    if (rx_code == PS2_F12 && !ext && !brk) begin
                        flap <= ~flap;
                    end
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_kbmatrix.sv
// Scoreboard bench for ps2_kbmatrix: the stimulus thread drives PS/2 frames and
// pushes the expected receiver event and matrix/flap state computed by a
// behavioural keyboard model; a monitor thread pops and compares on each
// rx_stb/rx_err pulse and again one cycle later.
`timescale 1ns/1ps
module tb_ps2_kbmatrix;
    import ps2_kb_pkg::*;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 20000;
    localparam int HALF        = 15;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [63:0] kbmatrix;
    logic        flap;
    logic [7:0]  rx_code;
    logic        rx_stb;
    logic        rx_err;

    always #5 clk = ~clk;

    ps2_kbmatrix #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .kbmatrix (kbmatrix),
        .flap     (flap),
        .rx_code  (rx_code),
        .rx_stb   (rx_stb),
        .rx_err   (rx_err)
    );

    typedef struct {
        bit          is_err;
        logic [7:0]  code;
        logic [63:0] mat_pre;
        logic [63:0] mat_post;
        bit          flap_pre;
        bit          flap_post;
    } exp_t;

    typedef struct {
        bit         ext;
        logic [7:0] code;
        int         idx;
    } key_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    key_t codes[$];
    bit   mon_pending = 0;
    exp_t mon_e;

    // Keyboard model state
    bit          m_ext, m_brk, m_flap;
    logic [63:0] m_mat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_code(input bit e, input logic [7:0] c, input int idx);
        key_t k;
        k.ext = e; k.code = c; k.idx = idx;
        codes.push_back(k);
    endtask

    function automatic int lookup(input bit e, input logic [7:0] c);
        foreach (codes[i])
            if (codes[i].ext == e && codes[i].code == c) return codes[i].idx;
        return -1;
    endfunction

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_flap = 0; m_mat = '1;
    endtask

    task automatic model_byte(input logic [7:0] c);
        int k;
        if (c == 8'hE0) m_ext = 1;
        else if (c == 8'hF0) m_brk = 1;
        else if (c == 8'h00 || c == 8'hFF) begin
            m_mat = '1; m_ext = 0; m_brk = 0;
        end else begin
            k = lookup(m_ext, c);
            if (k >= 0) m_mat[k] = m_brk;
            if (c == 8'h07 && !m_ext && !m_brk) m_flap = ~m_flap;
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic drive_bit(input bit b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic drive_frame(input logic [7:0] d, input bit bad_par);
        logic p;
        p = bad_par ? ^d : ~^d;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(1'b1);
        repeat (60) @(negedge clk);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1; e.code = 8'h00; e.mat_pre = m_mat; e.flap_pre = m_flap;
        m_ext = 0; m_brk = 0;
        e.mat_post = m_mat; e.flap_post = m_flap;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] c);
        exp_t e;
        e.is_err = 0; e.code = c; e.mat_pre = m_mat; e.flap_pre = m_flap;
        model_byte(c);
        e.mat_post = m_mat; e.flap_post = m_flap;
        exp_q.push_back(e);
        drive_frame(c, 1'b0);
    endtask

    task automatic send_bad(input logic [7:0] c);
        push_err();
        drive_frame(c, 1'b1);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mon_pending = 0;
            end else begin
                if (mon_pending) begin
                    check("kbmatrix_post", kbmatrix, mon_e.mat_post);
                    check("flap_post", 64'(flap), 64'(mon_e.flap_post));
                    mon_pending = 0;
                end
                if (rx_stb || rx_err) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_event", 64'({rx_stb, rx_err}), 64'd0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("event_kind", 64'({rx_stb, rx_err}), mon_e.is_err ? 64'd1 : 64'd2);
                        if (!mon_e.is_err) check("rx_code", 64'(rx_code), 64'(mon_e.code));
                        check("kbmatrix_pre", kbmatrix, mon_e.mat_pre);
                        mon_pending = 1;
                    end
                end
            end
        end
    endtask

    task automatic random_events(input int n);
        int   r;
        key_t k;
        bit   b;
        for (int i = 0; i < n; i++) begin
            r = int'($urandom_range(0, 19));
            k = codes[$urandom_range(0, codes.size() - 1)];
            b = 1'($urandom_range(0, 1));
            if (r < 14) begin
                if (k.ext) send_byte(8'hE0);
                if (b) send_byte(8'hF0);
                send_byte(k.code);
            end else if (r < 17) begin
                if (b) send_byte(8'hF0);
                send_byte(8'h07);
            end else if (r == 17) begin
                send_byte(8'h00);
            end else begin
                if (b) send_byte(8'hF0);
                send_bad(k.code);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_kbmatrix"}, kbmatrix, 64'hFFFF_FFFF_FFFF_FFFF);
        check({tag, "_flap"}, 64'(flap), 64'd0);
        check({tag, "_rx_code"}, 64'(rx_code), 64'd0);
        check({tag, "_rx_stb"}, 64'(rx_stb), 64'd0);
        check({tag, "_rx_err"}, 64'(rx_err), 64'd0);
    endtask

    initial begin
        add_code(0, 8'h1C, KEY_A);      add_code(1, 8'h75, KEY_UP);
        add_code(0, 8'h12, KEY_LSHIFT); add_code(0, 8'h59, KEY_RSHIFT);
        add_code(0, 8'h29, KEY_SPACE);  add_code(0, 8'h5A, KEY_ENTER);
        add_code(1, 8'h6B, KEY_LEFT);   add_code(0, 8'h15, KEY_Q);
        add_code(0, 8'h75, -1);         add_code(0, 8'h7C, -1);
        add_code(1, 8'h1C, -1);
        model_reset();

        fork
            monitor();
        join_none

        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (20) @(negedge clk);

        // Make and break of A
        send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h1C);

        // Extended UP, then plain keypad 8 which must not touch UP
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        send_byte(8'h75);

        // Bad parity clears a pending break; next A is a make
        send_byte(8'hF0);
        send_bad(8'h1C);
        send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h1C);

        // Timeout after start + 4 data bits, then a clean left shift and right shift
        push_err();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        ps2_data = 1'b1;
        repeat (TIMEOUT_CYC + 100) @(negedge clk);
        send_byte(8'h12);
        send_byte(8'h59);

        // Overflow with keys held, then flap toggling
        send_byte(8'h1C);
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hFF);
        send_byte(8'h07);
        send_byte(8'hF0); send_byte(8'h07);
        send_byte(8'h07);
        send_byte(8'h07);

        // Short clock glitch with data low must not start a frame
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk  = 1'b1;
        repeat (5) @(negedge clk);
        ps2_data = 1'b1;
        repeat (50) @(negedge clk);
        send_byte(8'h1C);

        random_events(25);

        // Reset in the middle of a frame, with keys held and flap forced open
        if (!m_flap) send_byte(8'h07);
        send_byte(8'h29);
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
        reset_n = 1'b0;
        ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("midreset");
        model_reset();
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check_reset_outputs("postreset");
        send_byte(8'h1C);

        for (int i = 0; i < 2000 && (exp_q.size() != 0 || mon_pending); i++) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
